mem_req_arbiter: RTL and testbench
==================================

# mem_req_arbiter

Round-robin arbiter that shares one look-ahead-buffered memory controller FSM (inputs mem, rw, burst; states IDLE, READ1..READ4, WRITE) among NREQ requesters. It picks one pending request and issues it to the controller as a one-cycle mem pulse with rw/burst held valid. It then tracks controller occupancy, so a new request is issued only when the controller is back in IDLE. It sits between the requesting masters and the controller, and it drives the controller's mem/rw/burst inputs directly.

## Interface
- NREQ, default 2, number of requesters (≥2); index width IW = $clog2(NREQ)
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset; the design is in reset while reset = 0
- req  input  NREQ  per-requester request level; sampled only in arbiter IDLE
- req_rw  input  NREQ  per-requester direction: 1 = read, 0 = write
- req_burst  input  NREQ  per-requester burst flag; meaningful only when req_rw = 1
- gnt  output  NREQ  one-hot, one-cycle pulse in the ISSUE cycle of the granted requester
- done  output  NREQ  one-hot, one-cycle pulse in the last controller-occupied cycle
- mem  output  1  to controller; 1 only in the ISSUE cycle
- rw  output  1  to controller; held from ISSUE through the end of WAIT
- burst  output  1  to controller; equals burst&rw of the granted request, held from ISSUE through the end of WAIT
- busy  output  1  1 in ISSUE and WAIT

## Operation
- States:
  - IDLE → ISSUE when |req is true.
  - ISSUE → WAIT unconditionally.
  - WAIT → IDLE when cnt == 0; otherwise cnt decrements.
- Selection in IDLE:
  - The first requester i with req[i] = 1, scanning ptr, ptr+1, …, NREQ-1, 0, … (wrapping modulo NREQ).
  - Register idx, rw_r = req_rw[idx], bst_r = req_burst[idx] & req_rw[idx].
- Pointer: ptr <= (idx+1) mod NREQ on entering ISSUE. When idx = NREQ-1, ptr wraps to 0.
- WAIT counter: loaded on ISSUE→WAIT with OCC-1, where OCC = 4 for a burst read and 1 for a single read or a write.
- All outputs are registered (look-ahead): next values are computed from next_state and driven from flops, so no combinational path from req to the controller.
- A requester holds req, req_rw and req_burst stable until its gnt. Dropping req before gnt is legal; the request is simply not seen.
- Requests arriving during ISSUE or WAIT are ignored until the next IDLE.
- If several requests are pending, the one at or after ptr wins. A requester just granted has lowest priority next round.

## Timing
- Reset values:
  - gnt = 0, done = 0, mem = 0, rw = 0, burst = 0, busy = 0.
  - state = IDLE, ptr = 0, cnt = 0.
- Reset mid-operation: the transaction is abandoned and no done pulse is issued. The controller is reset by the same reset.
- Cycle k: IDLE with a request pending.
- Cycle k+1 (ISSUE):
  - mem = 1, gnt[idx] = 1, rw and burst valid.
  - The controller, still in IDLE, samples mem, rw.
- WAIT, single read or write: cycle k+2, one cycle, matching controller READ1/WRITE; done[idx] = 1 in that cycle. IDLE at k+3, next ISSUE at k+4 at the earliest.
- WAIT, burst read: cycles k+2..k+5, matching READ1..READ4. burst = 1 during k+2 so READ1 sees it; done pulses at k+5. IDLE at k+6.
- Request-to-gnt latency: 1 cycle from the IDLE sample. Back-to-back issue spacing: 3 cycles (single) and 6 cycles (burst).
- A write with req_burst = 1 drives burst = 0 and uses OCC = 1.

## Structure
- Package mem_arb_pkg:
  - arb_state_t enum {IDLE, ISSUE, WAIT}, one-hot encoded, matching the controller's encoding style.
  - Constants OCC_SINGLE = 1, OCC_BURST = 4.
  - Shared with the controller's state typedef.
- Sub-module rr_pick: purely combinational; inputs req[NREQ] and ptr[IW]; outputs valid and idx[IW]. It is reused by other arbiters.
- The top level holds the FSM, ptr, cnt and the output flops.

## Test plan
- Reset: assert reset = 0 mid-burst (WAIT, cnt = 2), release → all outputs 0, ptr = 0, no done, next grant goes to requester 0.
- Single read: NREQ = 2, req = 01, req_rw = 01, req_burst = 00 → gnt = 01 and mem = 1 one cycle later; done = 01 in the following cycle; busy high for exactly 2 cycles.
- Burst read: req[1] with rw = 1, burst = 1 → mem pulse, burst = 1 held for 5 cycles (ISSUE plus 4 WAIT), done = 10 on the 4th WAIT cycle, next ISSUE no earlier than 6 cycles after the previous one.
- Round-robin fairness: req = 11 held continuously, both single writes → grant order 01, 10, 01, 10, with each gnt 3 cycles apart.
- Write with burst flag: req_rw = 0, req_burst = 1 → burst output 0, done after one WAIT cycle.
- Ignored requests: assert req[1] only during WAIT of requester 0 and drop it before IDLE → no gnt to requester 1. Then check that NREQ = 4 wrap takes ptr from 3 to 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the memory request arbiter and the
// look-ahead-buffered memory controller it feeds.
//   arb_state_t   : arbiter FSM states (one-hot)
//   ctrl_state_t  : controller FSM states (one-hot, same encoding style)
//   OCC_SINGLE    : controller-occupied cycles for a single read or a write
//   OCC_BURST     : controller-occupied cycles for a burst read
//   wait_load()   : value loaded into the WAIT counter for a transaction
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        ISSUE = 3'b010,
        WAIT  = 3'b100
    } arb_state_t;

    typedef enum logic [5:0] {
        C_IDLE  = 6'b000001,
        C_READ1 = 6'b000010,
        C_READ2 = 6'b000100,
        C_READ3 = 6'b001000,
        C_READ4 = 6'b010000,
        C_WRITE = 6'b100000
    } ctrl_state_t;

    localparam int unsigned OCC_SINGLE = 32'd1;
    localparam int unsigned OCC_BURST  = 32'd4;

    // Wide enough to hold OCC_BURST-1.
    localparam int unsigned CNT_W = 32'd2;

    // WAIT lasts OCC cycles, so the counter starts at OCC-1 and the
    // transaction ends in the cycle where it reads zero.
    function automatic logic [CNT_W-1:0] wait_load(input logic is_burst);
        logic [CNT_W-1:0] v;
        if (is_burst) begin
            v = CNT_W'(OCC_BURST - 32'd1);
        end else begin
            v = CNT_W'(OCC_SINGLE - 32'd1);
        end
        return v;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker: returns the first pending request
// at or after ptr, wrapping modulo NREQ.
//   req   [NREQ-1:0] : pending request levels
//   ptr   [IW-1:0]   : highest-priority position
//   valid            : at least one request pending
//   idx   [IW-1:0]   : index of the winning request (0 when !valid)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    // Position of the k-th candidate after ptr, wrapped into 0..NREQ-1.
    function automatic logic [IW-1:0] cand(input logic [IW-1:0] base, input int k);
        int sum;
        sum = (int'(base) + k) % NREQ;
        return IW'(sum);
    endfunction

    logic [IW-1:0] c_s;

    // Scan from the farthest candidate to the nearest one so that the nearest
    // pending request is the last one written and therefore wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        c_s   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            c_s   = cand(ptr, k);
            valid = valid | req[c_s];
            idx   = req[c_s] ? c_s : idx;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
// Round-robin arbiter sharing one memory controller among NREQ requesters.
// A pending request is picked in IDLE, issued to the controller as a one-cycle
// mem pulse (ISSUE), and the arbiter then waits (WAIT) until the controller
// is back in its IDLE state before sampling requests again.
// All outputs come straight from flops whose next values follow next_state,
// so there is no combinational path from req to the controller.
//   clk                : system clock, rising edge
//   reset              : asynchronous, active-low reset
//   req       [NREQ]   : request levels, sampled only in IDLE
//   req_rw    [NREQ]   : 1 = read, 0 = write
//   req_burst [NREQ]   : burst flag, honoured only for reads
//   gnt       [NREQ]   : one-hot pulse in the ISSUE cycle
//   done      [NREQ]   : one-hot pulse in the last controller-occupied cycle
//   mem                : controller start, high only in ISSUE
//   rw, burst          : controller direction/burst, held ISSUE..end of WAIT
//   busy               : high in ISSUE and WAIT
// -----------------------------------------------------------------------------
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] req_rw,
    input  logic [NREQ-1:0] req_burst,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] done,
    output logic            mem,
    output logic            rw,
    output logic            burst,
    output logic            busy
);

    localparam int IW = $clog2(NREQ);

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // The requester just served drops to lowest priority.
    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
        logic [IW-1:0] r;
        if (i == IW'(NREQ - 1)) begin
            r = '0;
        end else begin
            r = i + IW'(1);
        end
        return r;
    endfunction

    arb_state_t       state_q, state_d;
    logic [IW-1:0]    ptr_q,   ptr_d;
    logic [IW-1:0]    idx_q,   idx_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             rw_q,    rw_d;
    logic             burst_q, burst_d;
    logic [NREQ-1:0]  gnt_q,   gnt_d;
    logic [NREQ-1:0]  done_q,  done_d;
    logic             mem_q,   mem_d;
    logic             busy_q,  busy_d;

    logic             pick_valid_s;
    logic [IW-1:0]    pick_idx_s;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // Next state, pointer, WAIT counter and the latched transaction attributes.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    state_d = ISSUE;
                    idx_d   = pick_idx_s;
                    ptr_d   = next_ptr(pick_idx_s);
                    rw_d    = req_rw[pick_idx_s];
                    // A write never bursts, whatever its burst flag says.
                    burst_d = req_burst[pick_idx_s] & req_rw[pick_idx_s];
                end else begin
                    rw_d    = 1'b0;
                    burst_d = 1'b0;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = wait_load(burst_q);
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    rw_d    = 1'b0;
                    burst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                // Corrupted one-hot state: fall back to a clean IDLE.
                state_d = IDLE;
                cnt_d   = '0;
                rw_d    = 1'b0;
                burst_d = 1'b0;
            end
        endcase
    end

    // Look-ahead outputs: derived from the next state so they can be flopped.
    always_comb begin
        gnt_d  = '0;
        done_d = '0;
        mem_d  = 1'b0;
        busy_d = 1'b0;
        case (state_d)
            ISSUE: begin
                gnt_d  = onehot(idx_d);
                mem_d  = 1'b1;
                busy_d = 1'b1;
            end
            WAIT: begin
                busy_d = 1'b1;
                // The WAIT cycle with a zero count is the controller's last one.
                if (cnt_d == '0) begin
                    done_d = onehot(idx_d);
                end else begin
                    done_d = '0;
                end
            end
            default: begin
                gnt_d  = '0;
                done_d = '0;
                mem_d  = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            burst_q <= 1'b0;
            gnt_q   <= '0;
            done_q  <= '0;
            mem_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            burst_q <= burst_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            mem_q   <= mem_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign mem   = mem_q;
    assign rw    = rw_q;
    assign burst = burst_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_req_arbiter
// Scoreboard bench: a transaction-level model decides, from the arbitration
// rules, which requester is served and in which cycle; it queues one expected
// transaction per grant. A monitor pops an entry whenever the DUT issues and
// checks every output cycle by cycle against the popped transaction.
// Directed scenarios come first, then randomized traffic with reset pulses.
// -----------------------------------------------------------------------------
module tb_mem_req_arbiter;

    localparam int N     = 4;
    localparam int IW    = 2;
    localparam int OCC_S = 1;
    localparam int OCC_B = 4;

    logic         clk;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] req_rw;
    logic [N-1:0] req_burst;
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic         mem;
    logic         rw;
    logic         burst;
    logic         busy;

    mem_req_arbiter #(.NREQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_rw    (req_rw),
        .req_burst (req_burst),
        .gnt       (gnt),
        .done      (done),
        .mem       (mem),
        .rw        (rw),
        .burst     (burst),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   idx;
        logic rw_e;
        logic burst_e;
        int   issue;
        int   occ;
    } txn_t;

    txn_t exp_q[$];
    int   cyc      = 0;
    int   errors   = 0;
    int   checks   = 0;
    bit   hold_req = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks = checks + 1;
        if (act !== expv) begin
            errors = errors + 1;
            $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", nm, cyc, act, expv);
        end
    endtask

    // Reference model: at each rising edge, if the arbiter is free and some
    // request is pending, the first one at or after ptr is served. Its issue
    // cycle is the next one and the arbiter is free again after ISSUE + OCC.
    initial begin : model
        int          m_ptr;
        int          m_idle_from;
        int          w;
        logic [IW-1:0] p;
        txn_t        t;
        m_ptr       = 0;
        m_idle_from = 0;
        forever begin
            @(posedge clk);
            if (reset !== 1'b1) begin
                exp_q.delete();
                m_ptr       = 0;
                m_idle_from = 0;
            end else if (cyc >= m_idle_from && req != '0) begin
                w = -1;
                for (int s = 0; s < N; s++) begin
                    p = IW'((m_ptr + s) % N);
                    if (w < 0 && req[p]) w = int'(p);
                end
                p         = IW'(w);
                t.idx     = w;
                t.rw_e    = req_rw[p];
                t.burst_e = req_rw[p] & req_burst[p];
                t.occ     = t.burst_e ? OCC_B : OCC_S;
                t.issue   = cyc + 1;
                exp_q.push_back(t);
                m_ptr       = (w + 1) % N;
                m_idle_from = cyc + 2 + t.occ;
            end
            cyc = cyc + 1;
        end
    end

    // Monitor: pops on every DUT issue and checks all outputs each cycle.
    initial begin : monitor
        txn_t         cur;
        bit           cur_valid;
        logic [N-1:0] oh;
        logic [N-1:0] e_gnt;
        logic [N-1:0] e_done;
        logic         e_mem;
        logic         e_rw;
        logic         e_burst;
        logic         e_busy;
        cur_valid = 1'b0;
        cur       = '{idx: 0, rw_e: 1'b0, burst_e: 1'b0, issue: 0, occ: 0};
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                exp_q.delete();
                cur_valid = 1'b0;
                check("reset_outputs", 32'({gnt, done, mem, rw, burst, busy}), 32'd0);
            end else begin
                if (mem === 1'b1 || gnt !== '0) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_issue", 32'({mem, gnt}), 32'd0);
                    end else begin
                        cur       = exp_q.pop_front();
                        cur_valid = 1'b1;
                        check("issue_cycle", cyc, cur.issue);
                    end
                end
                if (exp_q.size() > 0 && exp_q[0].issue < cyc) begin
                    check("missed_issue", cyc, exp_q[0].issue);
                    exp_q.delete(0);
                end
                e_gnt   = '0;
                e_done  = '0;
                e_mem   = 1'b0;
                e_rw    = 1'b0;
                e_burst = 1'b0;
                e_busy  = 1'b0;
                if (cur_valid && cyc >= cur.issue && cyc <= cur.issue + cur.occ) begin
                    oh      = N'(1) << cur.idx;
                    e_busy  = 1'b1;
                    e_rw    = cur.rw_e;
                    e_burst = cur.burst_e;
                    if (cyc == cur.issue) begin
                        e_gnt = oh;
                        e_mem = 1'b1;
                    end
                    if (cyc == cur.issue + cur.occ) e_done = oh;
                end
                check("outputs{gnt,done,mem,rw,burst,busy}",
                      32'({gnt, done, mem, rw, burst, busy}),
                      32'({e_gnt, e_done, e_mem, e_rw, e_burst, e_busy}));
            end
        end
    end

    // Advance n cycles; inputs change 2 time units after the rising edge.
    // A granted requester drops its request unless hold_req is set.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            if (!hold_req) req = req & ~gnt;
        end
    endtask

    initial begin : driver
        logic [N-1:0] m;
        reset     = 1'b0;
        req       = '0;
        req_rw    = '0;
        req_burst = '0;
        step(3);
        reset = 1'b1;
        step(2);

        // Single read by requester 0.
        req_rw = 4'b0001; req_burst = 4'b0000; req = 4'b0001;
        step(6);

        // Two burst reads by requester 1, the second requested during WAIT.
        req_rw = 4'b0010; req_burst = 4'b0010; req = 4'b0010;
        step(2);
        req = 4'b0010;
        step(10);

        // Fairness: two writers holding their requests continuously.
        req_rw = 4'b0000; req_burst = 4'b0000;
        hold_req = 1'b1;
        req = 4'b0011;
        step(12);
        hold_req = 1'b0;
        req = 4'b0000;
        step(4);

        // Write carrying a burst flag.
        req_rw = 4'b0000; req_burst = 4'b0100; req = 4'b0100;
        step(6);

        // Requester 1 asks only while requester 0's burst occupies the controller.
        req_rw = 4'b0001; req_burst = 4'b0001; req = 4'b0001;
        step(3);
        req_rw = 4'b0011;
        req    = req | 4'b0010;
        step(2);
        req = req & ~4'b0010;
        step(6);

        // Pointer wrap from the last requester back to 0.
        req_rw = 4'b0000; req_burst = 4'b0000; req = 4'b1000;
        step(6);
        req = 4'b1001;
        step(8);

        // Reset in the middle of a burst (WAIT with two cycles left).
        req_rw = 4'b0010; req_burst = 4'b0010; req = 4'b0010;
        step(2);
        step(2);
        reset = 1'b0;
        step(2);
        req_rw = 4'b0000; req_burst = 4'b0000; req = 4'b1111;
        reset = 1'b1;
        step(20);

        // Randomized traffic: requests come and go, occasional reset pulses.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                m = N'(1) << i;
                if ((req & m) == '0) begin
                    if ($urandom_range(0, 3) == 0) begin
                        if ($urandom_range(0, 1) == 1) req_rw = req_rw | m;
                        else                           req_rw = req_rw & ~m;
                        if ($urandom_range(0, 1) == 1) req_burst = req_burst | m;
                        else                           req_burst = req_burst & ~m;
                        req = req | m;
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    req = req & ~m;
                end
            end
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b0;
                step(1);
                reset = 1'b1;
            end
            step(1);
        end
        req = '0;
        step(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
